dense_seq: RTL and testbench

Sequencer for a single fully connected neuron datapath.
- Walks the input and weight memories to compute N_OUT neurons, one after another, on one shared multiply-accumulate unit.
- Per neuron: accumulates N_IN signed products, adds a bias, passes the sum through the external sigmoid ALU, then emits the result on a valid/ready output port.
- Sits between the layer-level controller (start/done) and the input/weight/bias RAMs and sigmoid unit of a dense layer.

---
 rtl/dense_pkg.sv | 27 ++
 rtl/dense_mac.sv | 43 ++++
 rtl/dense_seq.sv | 160 ++++++++++++++++
 tb/tb_dense_seq.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/dense_pkg.sv
// Shared defaults, state encoding and address-width helpers for the dense-layer sequencer.
package dense_pkg;

    localparam int DEF_N_IN  = 64;
    localparam int DEF_N_OUT = 16;
    localparam int DEF_DW    = 8;
    localparam int DEF_ACCW  = 32;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MAC,
        S_BIAS,
        S_ACT,
        S_WRITE,
        S_DONE
    } state_t;

    // Width of an address bus for n words; a single-word memory still gets a 1-bit bus.
    function automatic int addr_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_IN_AW = addr_w(DEF_N_IN);
    localparam int DEF_W_AW  = addr_w(DEF_N_IN * DEF_N_OUT);
    localparam int DEF_B_AW  = addr_w(DEF_N_OUT);

endpackage

// File: rtl/dense_mac.sv
// Registered multiply-accumulate unit: signed DW x DW products and a captured bias
// are added into a wrapping two's-complement accumulator.
module dense_mac #(
    parameter int DW   = 8,
    parameter int AccW = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            clr,
    input  logic            mac_en,
    input  logic            bias_cap,
    input  logic            bias_add,
    input  logic [DW-1:0]   a,
    input  logic [DW-1:0]   b,
    input  logic [DW-1:0]   bias,
    output logic [AccW-1:0] acc
);

    logic signed [2*DW-1:0] prod;
    logic signed [DW-1:0]   bias_reg;
    logic [AccW-1:0]        acc_reg;

    assign prod = $signed(a) * $signed(b);
    assign acc  = acc_reg;

    // Sign-extending casts keep negative products/bias correct; the sum wraps freely.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bias_reg <= '0;
            acc_reg  <= '0;
        end else begin
            if (bias_cap)
                bias_reg <= bias;
            if (clr)
                acc_reg <= '0;
            else if (mac_en)
                acc_reg <= acc_reg + AccW'(prod);
            else if (bias_add)
                acc_reg <= acc_reg + AccW'(bias_reg);
        end
    end

endmodule

// File: rtl/dense_seq.sv
// Fully connected neuron sequencer: walks input/weight RAMs per neuron, adds bias,
// routes the sum through the sigmoid ALU and hands results out over valid/ready.
module dense_seq import dense_pkg::*; #(
    parameter int N_IN  = DEF_N_IN,
    parameter int N_OUT = DEF_N_OUT,
    parameter int DW    = DEF_DW,
    parameter int AccW  = DEF_ACCW
) (
    input  logic                              clk,
    input  logic                              rst_n,
    input  logic                              start,
    input  logic                              abort,
    output logic                              busy,
    output logic                              done,
    output logic                              rd_en,
    output logic [addr_w(N_IN)-1:0]           in_addr,
    output logic [addr_w(N_IN*N_OUT)-1:0]     w_addr,
    output logic [addr_w(N_OUT)-1:0]          b_addr,
    input  logic [DW-1:0]                     in_data,
    input  logic [DW-1:0]                     w_data,
    input  logic [DW-1:0]                     b_data,
    output logic [AccW-1:0]                   sig_x,
    input  logic [DW-1:0]                     sig_y,
    output logic                              out_valid,
    input  logic                              out_ready,
    output logic [DW-1:0]                     out_data,
    output logic [addr_w(N_OUT)-1:0]          out_idx
);

    localparam int IAW = addr_w(N_IN);
    localparam int WAW = addr_w(N_IN * N_OUT);
    localparam int JW  = addr_w(N_OUT);
    localparam int CW  = $clog2(N_IN + 1);

    localparam logic [CW-1:0] C_LAST = CW'(N_IN);
    localparam logic [JW-1:0] J_LAST = JW'(N_OUT - 1);

    state_t         state_reg, state_next;
    logic [JW-1:0]  j_reg, j_next;
    logic [CW-1:0]  c_reg, c_next;
    logic           out_valid_reg, out_valid_next;
    logic [DW-1:0]  out_data_reg, out_data_next;
    logic [JW-1:0]  out_idx_reg, out_idx_next;
    logic           mac_clr, mac_en, bias_cap, bias_add;

    dense_mac #(.DW(DW), .AccW(AccW)) u_mac (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (mac_clr),
        .mac_en   (mac_en),
        .bias_cap (bias_cap),
        .bias_add (bias_add),
        .a        (in_data),
        .b        (w_data),
        .bias     (b_data),
        .acc      (sig_x)
    );

    assign busy      = (state_reg != S_IDLE);
    assign done      = (state_reg == S_DONE);
    assign rd_en     = (state_reg == S_MAC) && (c_reg < C_LAST);
    assign in_addr   = rd_en ? IAW'(c_reg) : '0;
    assign w_addr    = rd_en ? (WAW'(j_reg) * WAW'(N_IN) + WAW'(c_reg)) : '0;
    assign b_addr    = j_reg;
    assign out_valid = out_valid_reg;
    assign out_data  = out_data_reg;
    assign out_idx   = out_idx_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= S_IDLE;
            j_reg         <= '0;
            c_reg         <= '0;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_idx_reg   <= '0;
        end else begin
            state_reg     <= state_next;
            j_reg         <= j_next;
            c_reg         <= c_next;
            out_valid_reg <= out_valid_next;
            out_data_reg  <= out_data_next;
            out_idx_reg   <= out_idx_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        j_next         = j_reg;
        c_next         = c_reg;
        out_valid_next = out_valid_reg;
        out_data_next  = out_data_reg;
        out_idx_next   = out_idx_reg;
        mac_clr        = 1'b0;
        mac_en         = 1'b0;
        bias_cap       = 1'b0;
        bias_add       = 1'b0;

        case (state_reg)
            S_IDLE: begin
                if (start) begin
                    state_next = S_MAC;
                    j_next     = '0;
                    c_next     = '0;
                    mac_clr    = 1'b1;
                end
            end
            S_MAC: begin
                // RAM data lags the address by one cycle, so products land at c = 1..N_IN.
                mac_en   = (c_reg != '0);
                bias_cap = (c_reg == CW'(1));
                if (c_reg == C_LAST)
                    state_next = S_BIAS;
                else
                    c_next = c_reg + CW'(1);
            end
            S_BIAS: begin
                bias_add   = 1'b1;
                state_next = S_ACT;
            end
            S_ACT: begin
                out_data_next  = sig_y;
                out_idx_next   = j_reg;
                out_valid_next = 1'b1;
                state_next     = S_WRITE;
            end
            S_WRITE: begin
                if (out_ready) begin
                    out_valid_next = 1'b0;
                    if (j_reg == J_LAST) begin
                        state_next = S_DONE;
                    end else begin
                        state_next = S_MAC;
                        j_next     = j_reg + JW'(1);
                        c_next     = '0;
                        mac_clr    = 1'b1;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase

        if (abort) begin
            state_next     = S_IDLE;
            out_valid_next = 1'b0;
            j_next         = '0;
            c_next         = '0;
            mac_clr        = 1'b1;
            mac_en         = 1'b0;
            bias_cap       = 1'b0;
            bias_add       = 1'b0;
        end
    end

endmodule

// File: tb/tb_dense_seq.sv
// Directed bench: a 4x2 layer for sequencing/timing/backpressure/abort/reset and a
// 2x2 layer with a 16-bit accumulator for signed products and wraparound.
module tb_dense_seq;

    logic clk;
    logic rst_n;

    // Instance A: N_IN=4, N_OUT=2, AccW=32
    logic        start_a, abort_a, busy_a, done_a, rd_en_a, out_valid_a, out_ready_a;
    logic [1:0]  in_addr_a;
    logic [2:0]  w_addr_a;
    logic [0:0]  b_addr_a, out_idx_a;
    logic [7:0]  in_data_a, w_data_a, b_data_a, sig_y_a, out_data_a;
    logic [31:0] sig_x_a;

    // Instance B: N_IN=2, N_OUT=2, AccW=16
    logic        start_b, abort_b, busy_b, done_b, rd_en_b, out_valid_b, out_ready_b;
    logic [0:0]  in_addr_b;
    logic [1:0]  w_addr_b;
    logic [0:0]  b_addr_b, out_idx_b;
    logic [7:0]  in_data_b, w_data_b, b_data_b, sig_y_b, out_data_b;
    logic [15:0] sig_x_b;

    logic [7:0] in_mem_a [4];
    logic [7:0] w_mem_a  [8];
    logic [7:0] b_mem_a  [2];
    logic [7:0] in_mem_b [2];
    logic [7:0] w_mem_b  [4];
    logic [7:0] b_mem_b  [2];

    int n_vec = 0;
    int n_err = 0;

    int first_valid, done_edge, done_cnt, idle_edge, stall_bad;
    logic [15:0] res_q[$];
    logic [15:0] sx_q[$];

    dense_seq #(.N_IN(4), .N_OUT(2), .DW(8), .AccW(32)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .start(start_a), .abort(abort_a),
        .busy(busy_a), .done(done_a), .rd_en(rd_en_a),
        .in_addr(in_addr_a), .w_addr(w_addr_a), .b_addr(b_addr_a),
        .in_data(in_data_a), .w_data(w_data_a), .b_data(b_data_a),
        .sig_x(sig_x_a), .sig_y(sig_y_a),
        .out_valid(out_valid_a), .out_ready(out_ready_a),
        .out_data(out_data_a), .out_idx(out_idx_a)
    );

    dense_seq #(.N_IN(2), .N_OUT(2), .DW(8), .AccW(16)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .start(start_b), .abort(abort_b),
        .busy(busy_b), .done(done_b), .rd_en(rd_en_b),
        .in_addr(in_addr_b), .w_addr(w_addr_b), .b_addr(b_addr_b),
        .in_data(in_data_b), .w_data(w_data_b), .b_data(b_data_b),
        .sig_x(sig_x_b), .sig_y(sig_y_b),
        .out_valid(out_valid_b), .out_ready(out_ready_b),
        .out_data(out_data_b), .out_idx(out_idx_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // One-cycle-latency RAM models and identity sigmoid stubs
    always @(posedge clk) begin
        if (rd_en_a) begin
            in_data_a <= in_mem_a[in_addr_a];
            w_data_a  <= w_mem_a[w_addr_a];
        end
        b_data_a <= b_mem_a[b_addr_a];
        if (rd_en_b) begin
            in_data_b <= in_mem_b[in_addr_b];
            w_data_b  <= w_mem_b[w_addr_b];
        end
        b_data_b <= b_mem_b[b_addr_b];
    end
    assign sig_y_a = sig_x_a[7:0];
    assign sig_y_b = sig_x_b[7:0];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s = %0h", tag, got);
        end
    endtask

    function automatic logic [15:0] res_at(input int k);
        return (res_q.size() > k) ? res_q[k] : 16'hFFFF;
    endfunction

    // Edge e = 0 is the edge that samples start; inputs for edge e+1 are driven after edge e.
    task automatic run_a(input int n_edges, input int stall_lo, input int stall_hi,
                         input int abort_at, input int sb_at);
        first_valid = -1; done_edge = -1; done_cnt = 0; idle_edge = -1; stall_bad = 0;
        res_q.delete();
        start_a = 1'b1;
        for (int e = 0; e < n_edges; e++) begin
            @(posedge clk); #1;
            start_a     = (e == sb_at);
            abort_a     = (e == abort_at);
            out_ready_a = !(e >= stall_lo && e < stall_hi);
            if (out_valid_a && first_valid < 0) first_valid = e;
            if (done_a) begin
                done_cnt++;
                if (done_edge < 0) done_edge = e;
            end
            if (!busy_a && idle_edge < 0) idle_edge = e;
            if (e >= stall_lo && e < stall_hi &&
                !(out_valid_a && out_data_a == 8'd10 && out_idx_a == 1'b0)) stall_bad++;
            if (out_valid_a && out_ready_a) res_q.push_back({8'(out_idx_a), out_data_a});
        end
        start_a = 1'b0; abort_a = 1'b0; out_ready_a = 1'b1;
    endtask

    initial begin
        in_mem_a = '{8'd1, 8'd2, 8'd3, 8'd4};
        w_mem_a  = '{8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
        b_mem_a  = '{8'd0, 8'd5};
        in_mem_b = '{8'h80, 8'h80};
        w_mem_b  = '{8'h80, 8'h00, 8'h80, 8'h80};
        b_mem_b  = '{8'hFF, 8'h00};
        start_a = 0; abort_a = 0; out_ready_a = 1;
        start_b = 0; abort_b = 0; out_ready_b = 1;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_ctrl", {busy_a, done_a, rd_en_a, out_valid_a}, 4'b0000);
        check("rst_out",  {out_data_a, 7'd0, out_idx_a}, 16'h0000);
        check("rst_addr", {in_addr_a, w_addr_a, b_addr_a}, 6'd0);
        check("rst_acc",  sig_x_a, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Plain layer; start is re-pulsed during the DONE cycle and must be ignored
        run_a(24, -1, -1, -1, 16);
        check("first_valid", first_valid, 7);
        check("done_edge",   done_edge, 16);
        check("done_cnt",    done_cnt, 1);
        check("res_cnt",     res_q.size(), 2);
        check("res0",        res_at(0), 16'h000A);
        check("res1",        res_at(1), 16'h010F);
        check("idle_after",  busy_a, 1'b0);

        // Backpressure: 5 stalled WRITE cycles on neuron 0, plus a start while busy
        run_a(30, 7, 12, -1, 3);
        check("bp_stable",   stall_bad, 0);
        check("bp_done",     done_edge, 21);
        check("bp_done_cnt", done_cnt, 1);
        check("bp_res0",     res_at(0), 16'h000A);
        check("bp_res1",     res_at(1), 16'h010F);

        // Abort during neuron 1 MAC (asserted for edge 10)
        run_a(20, -1, -1, 9, -1);
        check("ab_idle",     idle_edge, 10);
        check("ab_done_cnt", done_cnt, 0);
        check("ab_res_cnt",  res_q.size(), 1);
        check("ab_valid",    out_valid_a, 1'b0);
        check("ab_acc",      sig_x_a, 32'd0);

        // Restart after abort begins at neuron 0 with a clean accumulator
        run_a(20, -1, -1, -1, -1);
        check("rs_done",     done_edge, 16);
        check("rs_res0",     res_at(0), 16'h000A);
        check("rs_res1",     res_at(1), 16'h010F);

        // Reset asserted while parked in WRITE
        start_a = 1'b1; out_ready_a = 1'b0;
        @(posedge clk); #1;
        start_a = 1'b0;
        repeat (7) begin @(posedge clk); #1; end
        check("pre_rst_valid", {out_valid_a, out_data_a}, 9'h10A);
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ctrl", {busy_a, done_a, rd_en_a, out_valid_a}, 4'b0000);
        check("mid_rst_out",  {out_data_a, 7'd0, out_idx_a, 6'd0, in_addr_a, w_addr_a, b_addr_a}, 32'd0);
        check("mid_rst_acc",  sig_x_a, 32'd0);
        done_cnt = 0;
        repeat (3) begin
            @(negedge clk);
            if (done_a) done_cnt++;
        end
        out_ready_a = 1'b1;
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            if (done_a) done_cnt++;
        end
        check("mid_rst_nodone", done_cnt, 0);

        // Signed products and 16-bit wraparound on instance B
        res_q.delete(); sx_q.delete(); done_edge = -1;
        start_b = 1'b1;
        for (int e = 0; e < 16; e++) begin
            @(posedge clk); #1;
            start_b = 1'b0;
            if (e == 4 || e == 10) sx_q.push_back(sig_x_b);
            if (done_b && done_edge < 0) done_edge = e;
            if (out_valid_b && out_ready_b) res_q.push_back({8'(out_idx_b), out_data_b});
        end
        check("sgn_acc",  (sx_q.size() > 0) ? sx_q[0] : 16'h5555, 16'h3FFF);
        check("wrap_acc", (sx_q.size() > 1) ? sx_q[1] : 16'h5555, 16'h8000);
        check("sgn_res",  res_at(0), 16'h00FF);
        check("wrap_res", res_at(1), 16'h0100);
        check("b_done",   done_edge, 12);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
